// File: rtl/range_scan_source_if.sv
// Sample interface between the rangefinder mapper and the scan source, plus the
// sample BRAM read port and an FSM state view for checkers.
interface range_scan_source_if;
   logic        transmit;
   logic [10:0] mem_addr;
   logic [15:0] mem_data;
   logic [27:0] data_enable_step;
   logic        busy;
   logic        done;
   logic [7:0]  dropped_reqs;
   logic [2:0]  state_dbg;

   modport slave (
      input  transmit,
      input  mem_data,
      output mem_addr,
      output data_enable_step,
      output busy,
      output done,
      output dropped_reqs,
      output state_dbg
   );

   modport master (
      output transmit,
      output mem_data,
      input  mem_addr,
      input  data_enable_step,
      input  busy,
      input  done,
      input  dropped_reqs,
      input  state_dbg
   );
endinterface

// File: rtl/range_scan_source.sv
// Replays one scan from a sample BRAM as a paced {data, enable, step} stream each
// time the rangefinder mapper raises transmit.
module range_scan_source #(
   parameter int          NUM_STEPS   = 682,
   parameter int          HOLD_CYCLES = 4,
   parameter int          GAP_CYCLES  = 4,
   parameter logic [15:0] MIN_VALID   = 16'd20,
   parameter logic [15:0] MAX_RANGE   = 16'd4095
) (
   input  logic                clk,
   input  logic                reset,
   range_scan_source_if.slave  bus
);

   // Handshake: a request is the rising edge of transmit, there is no ready; one
   // request may wait in the pending slot while busy, later ones are counted as
   // dropped. Each sample is offered by enable held high for HOLD_CYCLES with
   // data/step stable, and the consumer must take it without backpressure.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [10:0] LAST_STEP = 11'(NUM_STEPS - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic        transmit_q;
   logic        req;
   logic [10:0] step_q, step_d;
   logic [10:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] data_q, data_d;
   logic [10:0] out_step_q, out_step_d;
   logic        pending_q, pending_d;
   logic [7:0]  dropped_q, dropped_d;

   function automatic logic [15:0] clamp_sample(input logic [15:0] raw);
      if (raw < MIN_VALID)
         return 16'hFFFF;
      else if (raw > MAX_RANGE)
         return MAX_RANGE;
      else
         return raw;
   endfunction

   assign req = bus.transmit & ~transmit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         transmit_q <= 1'b0;
         step_q     <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         out_step_q <= '0;
         pending_q  <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         transmit_q <= bus.transmit;
         step_q     <= step_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         out_step_q <= out_step_d;
         pending_q  <= pending_d;
         dropped_q  <= dropped_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      out_step_d = out_step_q;
      pending_d  = pending_q;
      dropped_d  = dropped_q;

      case (state_q)
         S_IDLE: begin
            if (req || pending_q) begin
               state_d   = S_FETCH;
               step_d    = '0;
               addr_d    = '0;
               pending_d = 1'b0;
            end
         end
         S_FETCH: begin
            addr_d  = step_q;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // BRAM word for step_q is on mem_data now; bus fields change only here,
            // while enable is low.
            data_d     = clamp_sample(bus.mem_data);
            out_step_d = step_q;
            cnt_d      = '0;
            state_d    = S_PRESENT;
         end
         S_PRESENT: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
               end else begin
                  // Address leads into FETCH so the synchronous BRAM has a full cycle.
                  step_d  = step_q + 11'd1;
                  addr_d  = step_q + 11'd1;
                  state_d = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (req && (state_q != S_IDLE)) begin
         if (!pending_q)
            pending_d = 1'b1;
         else if (dropped_q != 8'hFF)
            dropped_d = dropped_q + 8'd1;
      end
   end

   assign bus.mem_addr         = addr_q;
   assign bus.data_enable_step = {data_q, (state_q == S_PRESENT), out_step_q};
   assign bus.busy             = (state_q != S_IDLE);
   assign bus.done             = (state_q == S_DONE);
   assign bus.dropped_reqs     = dropped_q;
   assign bus.state_dbg        = state_q;

endmodule
